alt_vipvfr131_common_control_packet_decoder: RTL and testbench

- Avalon-ST video sink stage, the upstream counterpart of the control packet encoder.
- Parses the incoming VIP stream by packet type and extracts width, height and interlace from control packets (type 0xF).
- Forwards only the payload of video packets (type 0x0), header stripped, to the internal user-algorithm interface, marking the last beat as end_of_video.
- Discards all other packet types (1-14).

---
 rtl/alt_vipvfr131_common_pkg.sv | 34 +++
 rtl/alt_vipvfr131_common_ctrl_symbol_capture.sv | 56 +++++
 rtl/alt_vipvfr131_common_control_packet_decoder.sv | 135 +++++++++++++
 tb/tb_alt_vipvfr131_common_control_packet_decoder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alt_vipvfr131_common_pkg.sv
// Shared constants for the VIP control packet encoder/decoder pair.
// Packet types, control symbol layout and the decoder state encoding.
package alt_vipvfr131_common_pkg;

    localparam logic [3:0] TYPE_VIDEO = 4'h0;
    localparam logic [3:0] TYPE_CTRL  = 4'hF;

    localparam int CTRL_SYMBOLS = 9;
    localparam int BEAT_CNT_W   = 4;

    localparam int SYM_W3  = 0;
    localparam int SYM_W2  = 1;
    localparam int SYM_W1  = 2;
    localparam int SYM_W0  = 3;
    localparam int SYM_H3  = 4;
    localparam int SYM_H2  = 5;
    localparam int SYM_H1  = 6;
    localparam int SYM_H0  = 7;
    localparam int SYM_INT = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CTRL    = 2'd1,
        ST_VIDEO   = 2'd2,
        ST_DISCARD = 2'd3
    } dec_state_e;

    function automatic dec_state_e header_state(input logic [3:0] pkt_type);
        if (pkt_type == TYPE_CTRL)  return ST_CTRL;
        if (pkt_type == TYPE_VIDEO) return ST_VIDEO;
        return ST_DISCARD;
    endfunction

endpackage

// File: rtl/alt_vipvfr131_common_ctrl_symbol_capture.sv
// Captures control packet nibbles into a 9-entry shadow by symbol index.
// 'shadow' already includes the beat being captured, so a commit can use it on the eop edge.
module alt_vipvfr131_common_ctrl_symbol_capture
    import alt_vipvfr131_common_pkg::*;
#(
    parameter int SYMBOLS_PER_BEAT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          capture,
    input  logic [BEAT_CNT_W-1:0]         beat_idx,
    input  logic [SYMBOLS_PER_BEAT*4-1:0] sym_data,
    output logic [CTRL_SYMBOLS*4-1:0]     shadow,
    output logic                          complete
);

    localparam logic [7:0] SPB_W = 8'(SYMBOLS_PER_BEAT);

    logic [7:0] sym_idx [SYMBOLS_PER_BEAT];
    logic [3:0] nib     [SYMBOLS_PER_BEAT];
    logic [3:0] shadow_q [CTRL_SYMBOLS];
    logic [3:0] shadow_d [CTRL_SYMBOLS];

    for (genvar j = 0; j < SYMBOLS_PER_BEAT; j++) begin : g_sym
        assign sym_idx[j] = 8'(beat_idx) * SPB_W + 8'(j);
        assign nib[j]     = sym_data[j*4 +: 4];
    end

    // Packet holds all symbols once the last lane of this beat reaches the interlace slot.
    assign complete = (sym_idx[SYMBOLS_PER_BEAT-1] >= 8'(CTRL_SYMBOLS - 1));

    always_comb begin
        for (int k = 0; k < CTRL_SYMBOLS; k++) shadow_d[k] = shadow_q[k];
        if (capture) begin
            for (int j = 0; j < SYMBOLS_PER_BEAT; j++) begin
                for (int k = 0; k < CTRL_SYMBOLS; k++) begin
                    if (sym_idx[j] == 8'(k)) shadow_d[k] = nib[j];
                end
            end
        end
    end

    always_comb begin
        shadow = '0;
        for (int k = 0; k < CTRL_SYMBOLS; k++) shadow[k*4 +: 4] = shadow_d[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CTRL_SYMBOLS; k++) shadow_q[k] <= 4'h0;
        end else begin
            for (int k = 0; k < CTRL_SYMBOLS; k++) shadow_q[k] <= shadow_d[k];
        end
    end

endmodule

// File: rtl/alt_vipvfr131_common_control_packet_decoder.sv
// Avalon-ST VIP sink: decodes control packets, forwards video payload, drops the rest.
//   state      | meaning
//   ST_IDLE    | waiting for a header (sop) beat
//   ST_CTRL    | collecting control packet symbols
//   ST_VIDEO   | forwarding video payload beats
//   ST_DISCARD | consuming an unsupported packet type
module alt_vipvfr131_common_control_packet_decoder
    import alt_vipvfr131_common_pkg::*;
#(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3
) (
    input  logic                                        clk,
    input  logic                                        rst,
    output logic                                        din_ready,
    input  logic                                        din_valid,
    input  logic                                        din_sop,
    input  logic                                        din_eop,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
    input  logic                                        dout_ready,
    output logic                                        dout_valid,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
    output logic                                        end_of_video,
    output logic [15:0]                                 width,
    output logic [15:0]                                 height,
    output logic [3:0]                                  interlaced,
    output logic                                        ctrl_update,
    output logic                                        ctrl_error
);

    dec_state_e                  state_q, state_d;
    logic [BEAT_CNT_W-1:0]       beat_q, beat_d;
    logic [15:0]                 width_q, width_d, height_q, height_d;
    logic [3:0]                  interlaced_q, interlaced_d;
    logic                        ctrl_update_q, ctrl_update_d;
    logic                        ctrl_error_q, ctrl_error_d;
    logic                        accept, capture, commit, complete;
    logic [3:0]                  pkt_type;
    logic [SYMBOLS_PER_BEAT*4-1:0] sym_data;
    logic [CTRL_SYMBOLS*4-1:0]   shadow;

    assign accept   = din_valid & din_ready;
    assign pkt_type = din_data[3:0];

    always_comb begin
        sym_data = '0;
        for (int j = 0; j < SYMBOLS_PER_BEAT; j++)
            sym_data[j*4 +: 4] = din_data[j*BITS_PER_SYMBOL +: 4];
    end

    alt_vipvfr131_common_ctrl_symbol_capture #(
        .SYMBOLS_PER_BEAT(SYMBOLS_PER_BEAT)
    ) u_capture (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .beat_idx (beat_q),
        .sym_data (sym_data),
        .shadow   (shadow),
        .complete (complete)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        capture      = 1'b0;
        commit       = 1'b0;
        ctrl_error_d = 1'b0;
        if (accept) begin
            if (din_sop) begin
                // Any sop resyncs; arriving mid-packet is itself an error.
                ctrl_error_d = (state_q != ST_IDLE) || (din_eop && pkt_type == TYPE_CTRL);
                beat_d       = '0;
                state_d      = din_eop ? ST_IDLE : header_state(pkt_type);
            end else begin
                case (state_q)
                    ST_CTRL: begin
                        capture = 1'b1;
                        if (din_eop) begin
                            state_d      = ST_IDLE;
                            commit       = complete;
                            ctrl_error_d = ~complete;
                        end else if (beat_q != '1) begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                    ST_VIDEO, ST_DISCARD: if (din_eop) state_d = ST_IDLE;
                    default: ;
                endcase
            end
        end
        ctrl_update_d = commit;
        width_d       = commit ? {shadow[SYM_W3*4 +: 4], shadow[SYM_W2*4 +: 4],
                                  shadow[SYM_W1*4 +: 4], shadow[SYM_W0*4 +: 4]} : width_q;
        height_d      = commit ? {shadow[SYM_H3*4 +: 4], shadow[SYM_H2*4 +: 4],
                                  shadow[SYM_H1*4 +: 4], shadow[SYM_H0*4 +: 4]} : height_q;
        interlaced_d  = commit ? shadow[SYM_INT*4 +: 4] : interlaced_q;
    end

    always_comb begin
        din_ready    = (state_q == ST_VIDEO) ? dout_ready : 1'b1;
        dout_valid   = din_valid & ~din_sop & (state_q == ST_VIDEO);
        dout_data    = din_data;
        end_of_video = dout_valid & din_eop;
        width        = width_q;
        height       = height_q;
        interlaced   = interlaced_q;
        ctrl_update  = ctrl_update_q;
        ctrl_error   = ctrl_error_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q        <= '0;
            width_q       <= '0;
            height_q      <= '0;
            interlaced_q  <= '0;
            ctrl_update_q <= 1'b0;
            ctrl_error_q  <= 1'b0;
        end else begin
            beat_q        <= beat_d;
            width_q       <= width_d;
            height_q      <= height_d;
            interlaced_q  <= interlaced_d;
            ctrl_update_q <= ctrl_update_d;
            ctrl_error_q  <= ctrl_error_d;
        end
    end

endmodule

// File: tb/tb_alt_vipvfr131_common_control_packet_decoder.sv
// Randomised packet-level bench for the control packet decoder (SPB=3) plus an SPB=1 build.
module tb_alt_vipvfr131_common_control_packet_decoder;

    localparam int BPS = 8;
    localparam int SPB = 3;
    localparam int DW  = BPS * SPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          din_ready, din_valid, din_sop, din_eop;
    logic [DW-1:0] din_data, dout_data;
    logic          dout_ready, dout_valid, end_of_video;
    logic [15:0]   width, height;
    logic [3:0]    interlaced;
    logic          ctrl_update, ctrl_error;

    logic          s1_din_ready, s1_din_valid, s1_din_sop, s1_din_eop;
    logic [7:0]    s1_din_data, s1_dout_data;
    logic          s1_dout_ready, s1_dout_valid, s1_end_of_video;
    logic [15:0]   s1_width, s1_height;
    logic [3:0]    s1_interlaced;
    logic          s1_ctrl_update, s1_ctrl_error;

    always #5 clk = ~clk;

    alt_vipvfr131_common_control_packet_decoder #(.BITS_PER_SYMBOL(BPS), .SYMBOLS_PER_BEAT(SPB)) dut (
        .clk(clk), .rst(rst), .din_ready(din_ready), .din_valid(din_valid), .din_sop(din_sop),
        .din_eop(din_eop), .din_data(din_data), .dout_ready(dout_ready), .dout_valid(dout_valid),
        .dout_data(dout_data), .end_of_video(end_of_video), .width(width), .height(height),
        .interlaced(interlaced), .ctrl_update(ctrl_update), .ctrl_error(ctrl_error));

    alt_vipvfr131_common_control_packet_decoder #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(1)) dut_spb1 (
        .clk(clk), .rst(rst), .din_ready(s1_din_ready), .din_valid(s1_din_valid), .din_sop(s1_din_sop),
        .din_eop(s1_din_eop), .din_data(s1_din_data), .dout_ready(s1_dout_ready),
        .dout_valid(s1_dout_valid), .dout_data(s1_dout_data), .end_of_video(s1_end_of_video),
        .width(s1_width), .height(s1_height), .interlaced(s1_interlaced),
        .ctrl_update(s1_ctrl_update), .ctrl_error(s1_ctrl_error));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: packet type in progress (-1 = none) and the control symbols seen so far.
    int          m_type;
    logic [3:0]  m_syms[$];
    logic [15:0] m_w, m_h;
    logic [3:0]  m_i;
    logic        m_upd, m_err;

    int rdy_mode = 0;
    int rdy_ph   = 0;
    int vid_cnt  = 0;
    int eov_cnt  = 0;
    logic [3:0] tx_syms[$];

    task automatic model_reset();
        m_type = -1; m_syms.delete();
        m_w = '0; m_h = '0; m_i = '0; m_upd = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_beat(input bit s, input bit e, input logic [DW-1:0] d);
        m_upd = 1'b0; m_err = 1'b0;
        if (s) begin
            if (m_type >= 0) m_err = 1'b1;
            m_syms.delete();
            if (e) begin
                if (d[3:0] == 4'hF) m_err = 1'b1;
                m_type = -1;
            end else begin
                m_type = int'(d[3:0]);
            end
        end else if (m_type == 15) begin
            for (int j = 0; j < SPB; j++) m_syms.push_back(d[j*BPS +: 4]);
            if (e) begin
                if (m_syms.size() >= 9) begin
                    m_w   = {m_syms[0], m_syms[1], m_syms[2], m_syms[3]};
                    m_h   = {m_syms[4], m_syms[5], m_syms[6], m_syms[7]};
                    m_i   = m_syms[8];
                    m_upd = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                m_type = -1;
            end
        end else if (m_type >= 0 && e) begin
            m_type = -1;
        end
    endtask

    task automatic step(input bit v, input bit s, input bit e, input logic [DW-1:0] d, output bit acc);
        bit exp_rdy, exp_dv;
        @(negedge clk);
        din_valid = v; din_sop = s; din_eop = e; din_data = d;
        case (rdy_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
            default: dout_ready = 1'($urandom_range(0, 1));
        endcase
        rdy_ph++;
        #1;
        exp_rdy = (m_type == 0) ? dout_ready : 1'b1;
        exp_dv  = v && !s && (m_type == 0);
        chk("din_ready", din_ready, exp_rdy);
        chk("dout_valid", dout_valid, exp_dv);
        chk("end_of_video", end_of_video, exp_dv && e);
        if (exp_dv) chk("dout_data", dout_data, d);
        if (dout_valid && din_ready) vid_cnt++;
        if (end_of_video && din_ready) eov_cnt++;
        acc = v && exp_rdy;
        @(posedge clk);
        if (acc) model_beat(s, e, d);
        else begin m_upd = 1'b0; m_err = 1'b0; end
        #1;
        chk("width", width, m_w);
        chk("height", height, m_h);
        chk("interlaced", interlaced, m_i);
        chk("ctrl_update", ctrl_update, m_upd);
        chk("ctrl_error", ctrl_error, m_err);
    endtask

    task automatic send_beat(input bit s, input bit e, input logic [DW-1:0] d);
        bit acc = 1'b0;
        for (int t = 0; t < 64 && !acc; t++) step(1'b1, s, e, d, acc);
        if (!acc) chk("accept_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(1'b0, 1'($urandom), 1'($urandom), DW'($urandom), acc);
    endtask

    task automatic send_header(input logic [3:0] typ, input bit e);
        logic [DW-1:0] d = DW'($urandom);
        d[3:0] = typ;
        send_beat(1'b1, e, d);
    endtask

    task automatic send_payload(input int n, input bit last_eop);
        for (int k = 0; k < n; k++) send_beat(1'b0, last_eop && (k == n - 1), DW'($urandom));
    endtask

    // Sends tx_syms packed SPB per beat; upper bits of every symbol are random noise.
    task automatic send_ctrl_syms(input bit eop_end);
        int nb = (tx_syms.size() + SPB - 1) / SPB;
        for (int b = 0; b < nb; b++) begin
            logic [DW-1:0] d = DW'($urandom);
            for (int j = 0; j < SPB; j++)
                if (b*SPB + j < tx_syms.size()) d[j*BPS +: 4] = tx_syms[b*SPB + j];
            send_beat(1'b0, eop_end && (b == nb - 1), d);
        end
    endtask

    task automatic load_whi(input logic [15:0] w, input logic [15:0] h, input logic [3:0] i);
        tx_syms = '{w[15:12], w[11:8], w[7:4], w[3:0], h[15:12], h[11:8], h[7:4], h[3:0], i};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; din_valid = 1'b0; s1_din_valid = 1'b0;
        #1;
        chk("rst_width", width, 16'h0);
        chk("rst_height", height, 16'h0);
        chk("rst_interlaced", interlaced, 4'h0);
        chk("rst_ctrl_update", ctrl_update, 1'b0);
        chk("rst_ctrl_error", ctrl_error, 1'b0);
        chk("rst_din_ready", din_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int upd1;
        rst = 1'b1; din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0; din_data = '0; dout_ready = 1'b1;
        s1_din_valid = 1'b0; s1_din_sop = 1'b0; s1_din_eop = 1'b0; s1_din_data = '0; s1_dout_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        send_beat(1'b1, 1'b0, 24'h00000F);
        send_beat(1'b0, 1'b0, 24'h080700);
        send_beat(1'b0, 1'b0, 24'h040000);
        send_beat(1'b0, 1'b1, 24'h000803);
        chk("t1_width", width, 16'h0780);
        chk("t1_height", height, 16'h0438);
        chk("t1_update", ctrl_update, 1'b1);
        idle(1);

        for (int mode = 0; mode < 2; mode++) begin
            rdy_mode = mode; rdy_ph = 0; vid_cnt = 0; eov_cnt = 0;
            send_beat(1'b1, 1'b0, 24'h000000);
            send_beat(1'b0, 1'b0, 24'hA1A1A1);
            send_beat(1'b0, 1'b0, 24'hA2A2A2);
            send_beat(1'b0, 1'b0, 24'hA3A3A3);
            send_beat(1'b0, 1'b1, 24'hA4A4A4);
            chk("video_beats", vid_cnt, 4);
            chk("video_eov", eov_cnt, 1);
        end
        rdy_mode = 0;

        send_header(4'hF, 1'b0);
        tx_syms = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        send_ctrl_syms(1'b1);
        chk("trunc_width", width, 16'h0780);
        chk("trunc_height", height, 16'h0438);
        idle(1);

        vid_cnt = 0;
        send_header(4'h5, 1'b0);
        send_payload(2, 1'b1);
        chk("discard_no_dout", vid_cnt, 0);
        send_header(4'h0, 1'b0);
        send_payload(2, 1'b0);
        send_header(4'hF, 1'b0);
        chk("midsop_error", ctrl_error, 1'b1);
        load_whi(16'h0500, 16'h02D0, 4'h0);
        send_ctrl_syms(1'b1);
        send_header(4'hF, 1'b0);
        send_payload(1, 1'b0);
        do_reset();
        send_beat(1'b0, 1'b1, 24'h123456);
        idle(1);

        for (int p = 0; p < 80; p++) begin
            int sel = $urandom_range(0, 9);
            rdy_mode = $urandom_range(0, 2);
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) begin
                send_header((sel < 4) ? 4'hF : 4'($urandom), 1'b1);
            end else if (sel < 4) begin
                send_header(4'hF, 1'b0);
                load_whi(16'($urandom), 16'($urandom), 4'($urandom));
                if (sel == 0) repeat ($urandom_range(1, 8)) void'(tx_syms.pop_back());
                else repeat ($urandom_range(0, 3)) tx_syms.push_back(4'($urandom));
                send_ctrl_syms($urandom_range(0, 6) != 0);
            end else begin
                send_header((sel < 8) ? 4'h0 : 4'($urandom_range(1, 14)), 1'b0);
                send_payload($urandom_range(1, 6), $urandom_range(0, 6) != 0);
            end
        end
        idle(2);

        upd1 = 0;
        load_whi(16'h0140, 16'h00F0, 4'h3);
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            s1_din_valid = 1'b1;
            s1_din_sop   = (b == 0);
            s1_din_eop   = (b == 9);
            s1_din_data  = 8'($urandom);
            s1_din_data[3:0] = (b == 0) ? 4'hF : tx_syms[b - 1];
            #1;
            if (s1_ctrl_update) upd1++;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s1_din_valid = 1'b0;
            #1;
            if (s1_ctrl_update) upd1++;
        end
        chk("spb1_width", s1_width, 16'h0140);
        chk("spb1_height", s1_height, 16'h00F0);
        chk("spb1_interlaced", s1_interlaced, 4'h3);
        chk("spb1_update_pulses", upd1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
